// File: rtl/clock_rate_scheduler.sv
// Phase-accumulator timebase whose increment is reprogrammed by round-robin
// arbitrated requesters; a new increment only takes effect at an accumulator wrap.
//
// state | meaning
// IDLE  | no update latched; arbitrate eligible requests
// PEND  | pend_inc/owner latched; waiting for a wrap (or frozen accumulator)
module clock_rate_scheduler #(
  parameter int          WIDTH       = 32,
  parameter int          NREQ        = 4,
  parameter int unsigned DEFAULT_INC = 86
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  inc_in,
  output logic [NREQ-1:0]        grant,
  output logic                   slowClk,
  output logic                   tick,
  output logic                   busy,
  output logic [WIDTH-1:0]       active_inc
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count, pend_inc;
  logic [WIDTH:0]   sum;
  logic             carry, latch, apply, found;
  logic [IW-1:0]    rr, rr_nx, owner, win, idx;
  logic [NREQ-1:0]  elig;

  assign sum     = {1'b0, count} + {1'b0, active_inc};
  assign carry   = sum[WIDTH];
  assign slowClk = count[WIDTH-1];
  assign busy    = (state == PEND);
  // a requester whose grant is showing this cycle may still hold req; ignore it
  assign elig    = req & ~grant;
  assign rr_nx   = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    apply    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          latch    = 1'b1;
          state_nx = PEND;
        end
      end
      PEND: begin
        // a zero increment never carries, so apply without waiting
        if (carry || (active_inc == '0)) begin
          apply    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      active_inc <= WIDTH'(DEFAULT_INC);
      pend_inc   <= '0;
      owner      <= '0;
      rr         <= '0;
      grant      <= '0;
      tick       <= 1'b0;
    end else begin
      state <= state_nx;
      count <= sum[WIDTH-1:0];
      tick  <= carry;
      grant <= '0;
      if (latch) begin
        pend_inc <= inc_in[win*WIDTH +: WIDTH];
        owner    <= win;
      end
      if (apply) begin
        active_inc   <= pend_inc;
        grant[owner] <= 1'b1;
        rr           <= rr_nx;
      end
    end
  end

endmodule

// File: tb/tb_clock_rate_scheduler.sv
// Bench for clock_rate_scheduler: integer reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requests.
module tb_clock_rate_scheduler;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] inc_in;
  logic [N-1:0] grant;
  logic         slowClk, tick, busy;
  logic [W-1:0] active_inc;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  clock_rate_scheduler #(.WIDTH(W), .NREQ(N), .DEFAULT_INC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .inc_in(inc_in), .grant(grant),
    .slowClk(slowClk), .tick(tick), .busy(busy), .active_inc(active_inc)
  );

  always #5 clk = ~clk;

  // reference model: plain integers, a pending flag and a rotating pointer
  int unsigned m_count, m_active, m_pinc, m_sum;
  int          m_owner, m_rr, m_i;
  bit          m_pend, m_wrap, m_tick;
  logic [N-1:0] m_grant, m_gnew;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0; m_active = 16; m_pinc = 0; m_pend = 0;
      m_owner = 0; m_rr = 0; m_grant = '0; m_tick = 0;
    end else begin
      m_sum  = m_count + m_active;
      m_wrap = (m_sum >= 256);
      m_gnew = '0;
      if (m_pend) begin
        if (m_wrap || m_active == 0) begin
          m_gnew[m_owner] = 1'b1;
          m_active = m_pinc;
          m_rr = (m_owner + 1) % N;
          m_pend = 0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          m_i = (m_rr + k) % N;
          if (!m_pend && req[m_i] && !m_grant[m_i]) begin
            m_pend = 1; m_owner = m_i; m_pinc = inc_in[m_i*W +: W];
          end
        end
      end
      m_count = m_sum % 256;
      m_tick  = m_wrap;
      m_grant = m_gnew;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual %0h required %0h", nm, cur, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_grant", 32'(grant), 32'(m_grant));
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_busy", 32'(busy), 32'(m_pend));
    chk("model_active_inc", 32'(active_inc), m_active);
    chk("model_slowClk", 32'(slowClk), 32'(m_count >= 128));
  end

  task automatic go_to(input int e);
    repeat (e - cur) @(negedge clk);
    cur = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1; req = '0; inc_in = '0;
    @(negedge clk);
    reset = 1'b0;
    cur = 0;
  endtask

  initial begin
    reset = 1'b1; req = '0; inc_in = '0;
    @(negedge clk);
    chk("reset_active_inc", 32'(active_inc), 32'd16);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy_tick_slow", {29'd0, busy, tick, slowClk}, 32'd0);
    reset = 1'b0; cur = 0;

    // free-running at default increment
    go_to(7);  chk("t1_slow_e7", 32'(slowClk), 32'd0);
    go_to(8);  chk("t1_slow_e8", 32'(slowClk), 32'd1);
    go_to(15); chk("t1_tick_e15", 32'(tick), 32'd0);
    go_to(16); chk("t1_tick_e16", 32'(tick), 32'd1);
    chk("t1_slow_e16", 32'(slowClk), 32'd0);
    go_to(17); chk("t1_tick_e17", 32'(tick), 32'd0);
    go_to(32); chk("t1_tick_e32", 32'(tick), 32'd1);
    chk("t1_grant", 32'(grant), 32'd0);

    // single request applied at the wrap
    do_reset();
    go_to(3);  req[0] = 1'b1; inc_in[7:0] = 8'd32;
    go_to(4);  chk("t2_busy_e4", 32'(busy), 32'd1);
    go_to(15); chk("t2_grant_e15", 32'(grant), 32'd0);
    go_to(16); chk("t2_grant_e16", 32'(grant), 32'd1);
    chk("t2_active_e16", 32'(active_inc), 32'd32);
    chk("t2_tick_e16", 32'(tick), 32'd1);
    req[0] = 1'b0;
    go_to(23); chk("t2_tick_e23", 32'(tick), 32'd0);
    go_to(24); chk("t2_tick_e24", 32'(tick), 32'd1);

    // two simultaneous requests, one per wrap
    do_reset();
    req = 4'b0101; inc_in[7:0] = 8'd32; inc_in[23:16] = 8'd64;
    go_to(16); chk("t3_grant0", 32'(grant), 32'd1);
    req[0] = 1'b0;
    go_to(23); chk("t3_grant_e23", 32'(grant), 32'd0);
    go_to(24); chk("t3_grant2", 32'(grant), 32'd4);
    chk("t3_active", 32'(active_inc), 32'd64);
    req[2] = 1'b0;

    // zero increment freezes, next request applies two cycles later
    req[1] = 1'b1; inc_in[15:8] = 8'd0;
    go_to(28); chk("t4_grant1", 32'(grant), 32'd2);
    chk("t4_active0", 32'(active_inc), 32'd0);
    req[1] = 1'b0;
    go_to(30); chk("t4_frozen_tick_e30", 32'(tick), 32'd0);
    go_to(32); chk("t4_frozen_tick_e32", 32'(tick), 32'd0);
    chk("t4_frozen_slow", 32'(slowClk), 32'd0);
    req[3] = 1'b1; inc_in[31:24] = 8'd64;
    go_to(33); chk("t4_grant_e33", 32'(grant), 32'd0);
    go_to(34); chk("t4_grant3", 32'(grant), 32'd8);
    req[3] = 1'b0;
    go_to(37); chk("t4_tick_e37", 32'(tick), 32'd0);
    go_to(38); chk("t4_tick_e38", 32'(tick), 32'd1);

    // held request is not re-granted before the other requester is served
    req[0] = 1'b1; inc_in[7:0] = 8'd128; req[1] = 1'b1; inc_in[15:8] = 8'd32;
    go_to(42); chk("t5_grant0", 32'(grant), 32'd1);
    go_to(43); chk("t5_grant_e43", 32'(grant), 32'd0);
    chk("t5_busy_e43", 32'(busy), 32'd1);
    go_to(44); chk("t5_grant1", 32'(grant), 32'd2);
    req[1] = 1'b0;
    go_to(51); chk("t5_grant_e51", 32'(grant), 32'd0);
    go_to(52); chk("t5_regrant0", 32'(grant), 32'd1);
    chk("t5_active", 32'(active_inc), 32'd128);
    req[0] = 1'b0;

    // reset while pending discards the update
    req[2] = 1'b1; inc_in[23:16] = 8'd200;
    go_to(53); chk("t6_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_active", 32'(active_inc), 32'd16);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_busy_tick_slow", {29'd0, busy, tick, slowClk}, 32'd0);
    @(negedge clk);
    chk("t6_grant_after", 32'(grant), 32'd0);
    req = '0; reset = 1'b0; cur = 0;

    // randomized requesters obeying the hold-until-grant protocol
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cur = c;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_grant[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          inc_in[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          req[i] = 1'b1;
        end
      end
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_rate_scheduler.md
# clock_rate_scheduler

Runtime-programmable phase-accumulator timebase shared by up to NREQ requesters, each of which may ask to change the output frequency. Requests are arbitrated round-robin, and the winning increment is applied only at an accumulator wrap, so `slowClk` never glitches or produces a runt phase. It sits between control logic (mode FSMs, UI) and any logic clocked or enabled by the divided clock.

## Interface
- `WIDTH`, 32: accumulator width in bits.
- `NREQ`, 4: number of requesters (≥2).
- `DEFAULT_INC`, 86: increment loaded at reset (≈1 Hz out from 50 MHz at WIDTH=32).
- `clk` in 1: system clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in NREQ: per-requester change request, level; hold until own `grant` bit pulses.
- `inc_in` in NREQ*WIDTH: requester i's increment in bits [i*WIDTH +: WIDTH]; stable while `req[i]` high.
- `grant` out NREQ: one-cycle pulse on bit i when requester i's increment becomes active.
- `slowClk` out 1: accumulator MSB.
- `tick` out 1: one-cycle pulse per accumulator wrap.
- `busy` out 1: high while a latched request awaits application (state PEND).
- `active_inc` out WIDTH: increment currently used by the accumulator.

## Operation
- Accumulator: every cycle, `{carry, count} <= count + active_inc` (WIDTH+1-bit add; the carry is the wrap). `slowClk = count[WIDTH-1]`.
- State machine, two states:
  - IDLE: if any eligible `req` bit is set, select the winner round-robin starting at pointer `rr`, latch its `inc_in` slice into `pend_inc`, record `owner`, go to PEND. Otherwise stay.
  - PEND: at the first edge where the add carries, or at the next edge if `active_inc == 0`, perform `active_inc <= pend_inc`, `grant[owner] <= 1`, `rr <= owner+1` (mod NREQ), then go to IDLE.
- Eligibility: `req[i]` is ignored in the cycle `grant[i]` is high. This prevents re-grant before the requester drops `req`.
- A `req` bit dropping while in PEND does not cancel the update. The latched value is applied and granted anyway.
- Requests arriving in PEND wait. Only one update is applied per wrap.
- `pend_inc == 0` is legal: the accumulator freezes, `slowClk` holds, and `tick` stops. A subsequent request then applies one cycle after it enters PEND.
- Same value as `active_inc`: processed normally (waits for wrap, grants).

## Timing
- Reset values: count 0, `active_inc` = DEFAULT_INC, state IDLE, `rr` 0, `grant` 0, `tick` 0, `busy` 0, `slowClk` 0.
- `tick` is registered: it is high in the cycle after the carrying edge, for exactly one cycle.
- Latency from `req` sampled in IDLE:
  - PEND on the next edge.
  - `grant` at the first subsequent carrying edge, or 1 cycle later if `active_inc` is 0.
- `grant` and the new `active_inc` are visible in the same cycle. The first add using the new increment happens at the following edge.
- The carrying edge that applies the update still uses the old increment for that add. The `tick` for that wrap is still generated.
- `busy` is high exactly in cycles where the state is PEND.
- Reset mid-PEND: the update is discarded, no `grant` is issued, and `active_inc` returns to DEFAULT_INC.

## Test plan
Bench uses WIDTH=8, NREQ=4, DEFAULT_INC=16.
1. Reset release, no requests -> count increments 16/cycle. `slowClk` rises after 8 cycles and falls at the wrap. `tick` pulses every 16 cycles. All `grant` bits stay 0.
2. Request 0 with inc=32 asserted at cycle 3 -> `busy` high from cycle 4. `grant[0]` and `active_inc`=32 appear in the cycle after the 16th edge. Thereafter `tick` pulses every 8 cycles. The `slowClk` period changes only at the wrap, with no short phase.
3. Requests 0 and 2 asserted together (incs 32 and 64), `rr`=0 -> `grant[0]` at the first wrap. `grant[2]` follows at the next wrap. `rr` ends at 3.
4. Requester 1 sets inc=0 and is granted -> count frozen, `tick` stops. Requester 3 then sets inc=64 -> `grant[3]` two cycles after `req[3]` rises. Wraps resume every 4 cycles.
5. Requester 0 holds `req` through its `grant` cycle -> no second grant in that cycle. It is re-granted only after requester 1, which is requesting, has been served.
6. Assert `reset` while in PEND -> all outputs return to reset values immediately. No `grant` pulse is issued. `active_inc`=16.
